unified_mem_initiator: RTL
==========================

Name: unified_mem_initiator

Overview:
- Initiator/master side of the unified single-ported instruction+data memory.
- Arbitrates between instruction fetch and load/store requests and issues word-addressed reads and byte-enabled writes.
- Formats load data by func3 (sign/zero extension, lane select) and replicates store data across byte lanes.
- Sits between the IF/MEM pipeline stages and the memory array; converts RISC-V byte-granular accesses into word accesses.

Parameters:
- ADDR_W, 12, byte-address width (4096-byte memory); word address is ADDR_W-2 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_valid  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- if_ready  out  1  fetch accepted this cycle.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched instruction word.
- ls_valid  in  1  load/store request.
- ls_write  in  1  1=store, 0=load.
- ls_func3  in  3  RISC-V funct3.
- ls_addr  in  ADDR_W  byte address.
- ls_wdata  in  32  store data (low bits used for SB/SH).
- ls_ready  out  1  load/store accepted this cycle.
- ls_done  out  1  one-cycle pulse; ls_rdata/ls_err valid.
- ls_err  out  1  illegal func3 or misaligned (see feature); qualified by ls_done.
- ls_rdata  out  32  formatted load data; 0 for stores/errors.
- mem_addr  out  ADDR_W-2  word address.
- mem_re  out  1  read strobe; mem_rdata valid the following cycle.
- mem_we  out  4  byte-lane write enables, written on the rising edge ending the strobe cycle.
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  read data, one cycle after mem_re.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=IF. All outputs 0 except if_ready/ls_ready, which follow IDLE arbitration. Any in-flight request is discarded with no done pulse and no strobe.
- FSM: IDLE -> ISSUE -> CAPT -> IDLE. Every accepted request takes exactly 3 cycles; throughput is one request per 3 cycles.
- IDLE:
  - Arbitration: ls wins if only ls_valid is high; if wins if only if_valid is high.
  - If both are valid, grant the requester not granted last (last_grant toggles).
  - ready = grant; the request is latched on acceptance.
  - if_ready and ls_ready are never both 1.
  - ready is 0 in ISSUE and CAPT.
- ISSUE (T+1): registered strobes driven for exactly this cycle.
  - Load/fetch: mem_re=1, mem_we=0.
  - Store: mem_re=0, mem_we per func3.
  - Error request: no strobes.
- CAPT (T+2): mem_rdata captured and formatted into an output register.
- T+3 (back in IDLE): if_done or ls_done pulses for one cycle. A new request may be accepted in this same cycle.
- Store lanes (off=addr[1:0]):
  - SB (000): mem_we=4'b0001<<off, mem_wdata={4{wdata[7:0]}}.
  - SH (001): mem_we=4'b0011<<{off[1],1'b0}, mem_wdata={2{wdata[15:0]}}.
  - SW (010): mem_we=4'b1111, mem_wdata=wdata.
  - Other func3: ls_err.
- Load format:
  - LB: sign-extended byte at lane off.
  - LH: sign-extended half at off[1].
  - LW: full word.
  - LBU/LHU: zero-extended byte/half.
  - func3 011/110/111: ls_err, ls_rdata=0.
- Fetch: always a word read; if_rdata = mem_rdata.
- if_rdata/ls_rdata hold their value until the next done of the same port.
- mem_addr = latched addr[ADDR_W-1:2] during ISSUE; 0 otherwise.

Optional Feature:
- Macro: UNIFIED_MEM_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with off[0]=1, or LW/SW with off!=0, give ls_err=1 at done.
  - No strobes are issued and ls_rdata=0; latency is unchanged.
- Undefined:
  - No misalignment errors; low address bits are forced.
  - Half accesses use off[1] only; word accesses ignore off.

Test Plan:
- Reset: hold rst_n=0 mid-ISSUE of a store -> mem_we=0 immediately, no ls_done afterwards, busy=0, ls_ready=1 with ls_valid high.
- SW addr 0x080, wdata 0xDEADBEEF -> ISSUE: mem_addr=0x020, mem_we=4'b1111, mem_wdata=0xDEADBEEF; ls_done at T+3 with ls_err=0.
- Memory word 0x020 = 0x8070F011:
  - LB 0x081 -> 0xFFFFFFF0.
  - LBU 0x081 -> 0x000000F0.
  - LH 0x082 -> 0xFFFF8070.
  - LHU 0x082 -> 0x00008070.
- SB 0x083 wdata 0x000000AB -> mem_we=4'b1000, mem_wdata=0xABABABAB; SH 0x082 wdata 0x1234 -> mem_we=4'b1100, mem_wdata=0x12341234.
- if_valid and ls_valid held high from reset -> grants alternate: ls, if, ls (accepts at cycles 0, 3, 6); if_done carries word at if_addr>>2; func3=011 load -> ls_err=1, no mem_re.
- LW 0x082:
  - Macro defined: ls_err=1, no mem_re.
  - Macro undefined: mem_addr=0x020, ls_rdata=0x8070F011.

Source files
------------

// File: rtl/unified_mem_if.sv
// Request/response and memory-side signals of the unified memory initiator.
// master = initiator view, slave = surrounding pipeline + memory array view.
interface unified_mem_if #(parameter int ADDR_W = 12);
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_done;
  logic [31:0]       if_rdata;

  logic              ls_valid;
  logic              ls_write;
  logic [2:0]        ls_func3;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_ready;
  logic              ls_done;
  logic              ls_err;
  logic [31:0]       ls_rdata;

  logic [ADDR_W-3:0] mem_addr;
  logic              mem_re;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  if_valid, if_addr,
    output if_ready, if_done, if_rdata,
    input  ls_valid, ls_write, ls_func3, ls_addr, ls_wdata,
    output ls_ready, ls_done, ls_err, ls_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output if_valid, if_addr,
    input  if_ready, if_done, if_rdata,
    output ls_valid, ls_write, ls_func3, ls_addr, ls_wdata,
    input  ls_ready, ls_done, ls_err, ls_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/unified_mem_initiator.sv
// Fetch/load-store arbiter and word-access formatter for the unified memory.
// Optional: define UNIFIED_MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module unified_mem_initiator #(
  parameter int ADDR_W = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  unified_mem_if.master bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPT = 2'd2} state_e;

  state_e state_q, state_d;
  logic   grant_ls, grant_if;

  logic              last_ls_q, last_ls_d;
  logic              req_ls_q, req_ls_d;
  logic              req_write_q, req_write_d;
  logic              req_err_q, req_err_d;
  logic [2:0]        req_f3_q, req_f3_d;
  logic [1:0]        req_off_q, req_off_d;
  logic              mem_re_q, mem_re_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic              ls_err_q, ls_err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic [1:0]  ls_off;
  logic [2:0]  ls_f3;
  logic        bad_f3, misalign, acc_err;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b010:  fmt_load = rd;
      3'b100:  fmt_load = {24'd0, b};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = 32'd0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ls || grant_if) state_d = ISSUE;
      ISSUE:   state_d = CAPT;
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: round-robin grant only when idle, ls wins ties if fetch went last
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (state_q == IDLE) begin
      grant_ls = bus.ls_valid && (!bus.if_valid || !last_ls_q);
      grant_if = bus.if_valid && !grant_ls;
    end
    bus.ls_ready = grant_ls;
    bus.if_ready = grant_if;
    busy         = (state_q != IDLE);
  end

  // Load/store request decode on the raw inputs, used at acceptance
  always_comb begin
    ls_off   = bus.ls_addr[1:0];
    ls_f3    = bus.ls_func3;
    bad_f3   = bus.ls_write ? (ls_f3 > 3'b010)
                            : (ls_f3 == 3'b011 || ls_f3 == 3'b110 || ls_f3 == 3'b111);
`ifdef UNIFIED_MEM_MISALIGN_TRAP_EN
    misalign = (ls_f3[1:0] == 2'b01 && ls_off[0]) || (ls_f3[1:0] == 2'b10 && ls_off != 2'b00);
`else
    misalign = 1'b0;
`endif
    acc_err  = bad_f3 || misalign;
    st_we    = 4'b0000;
    st_wdata = 32'd0;
    case (ls_f3)
      3'b000: begin
        st_we    = 4'b0001 << ls_off;
        st_wdata = {4{bus.ls_wdata[7:0]}};
      end
      3'b001: begin
        st_we    = 4'b0011 << {ls_off[1], 1'b0};
        st_wdata = {2{bus.ls_wdata[15:0]}};
      end
      3'b010: begin
        st_we    = 4'b1111;
        st_wdata = bus.ls_wdata;
      end
      default: ;
    endcase
  end

  // Datapath: strobes live for the ISSUE cycle only, results land at the CAPT edge
  always_comb begin
    last_ls_d   = last_ls_q;
    req_ls_d    = req_ls_q;
    req_write_d = req_write_q;
    req_err_d   = req_err_q;
    req_f3_d    = req_f3_q;
    req_off_d   = req_off_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_wdata_d = 32'd0;
    mem_addr_d  = '0;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    ls_err_d    = ls_err_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;

    if (grant_ls) begin
      last_ls_d   = 1'b1;
      req_ls_d    = 1'b1;
      req_write_d = bus.ls_write;
      req_err_d   = acc_err;
      req_f3_d    = ls_f3;
      req_off_d   = ls_off;
      mem_addr_d  = bus.ls_addr[ADDR_W-1:2];
      if (!acc_err) begin
        if (bus.ls_write) begin
          mem_we_d    = st_we;
          mem_wdata_d = st_wdata;
        end else begin
          mem_re_d = 1'b1;
        end
      end
    end else if (grant_if) begin
      last_ls_d   = 1'b0;
      req_ls_d    = 1'b0;
      req_write_d = 1'b0;
      req_err_d   = 1'b0;
      mem_addr_d  = bus.if_addr[ADDR_W-1:2];
      mem_re_d    = 1'b1;
    end

    if (state_q == CAPT) begin
      if (req_ls_q) begin
        ls_done_d  = 1'b1;
        ls_err_d   = req_err_q;
        ls_rdata_d = (req_err_q || req_write_q) ? 32'd0
                                                : fmt_load(req_f3_q, req_off_q, bus.mem_rdata);
      end else begin
        if_done_d  = 1'b1;
        if_rdata_d = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls_q   <= 1'b0;
      req_ls_q    <= 1'b0;
      req_write_q <= 1'b0;
      req_err_q   <= 1'b0;
      req_f3_q    <= 3'd0;
      req_off_q   <= 2'd0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
      mem_addr_q  <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      ls_rdata_q  <= 32'd0;
    end else begin
      last_ls_q   <= last_ls_d;
      req_ls_q    <= req_ls_d;
      req_write_q <= req_write_d;
      req_err_q   <= req_err_d;
      req_f3_q    <= req_f3_d;
      req_off_q   <= req_off_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      ls_err_q    <= ls_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.ls_err    = ls_err_q;
  assign bus.ls_rdata  = ls_rdata_q;

endmodule
